// File: rtl/adc_scan_sched_if.sv
// ADC-side bundle of the scan sequencer: chip/channel selects, conversion request and sample return.
interface adc_scan_sched_if;
    logic        cs0;
    logic        cs1;
    logic [2:0]  ch_sel;
    logic        conv_start;
    logic [12:0] adc_data;
    logic        adc_valid;

    modport master (output cs0, cs1, ch_sel, conv_start, input adc_data, adc_valid);
    modport slave  (input cs0, cs1, ch_sel, conv_start, output adc_data, adc_valid);
endinterface

// File: rtl/adc_scan_sched.sv
// Round-robin X/Y/Z scan of the accelerometer ADC pair with per-axis oversampled averaging.
//
// state | meaning
// IDLE  | chip selects released, waiting for ena
// SEL   | axis selected, settling for SETTLE cycles
// CONV  | one-cycle conversion request
// WAIT  | waiting for adc_valid, bounded by TIMEOUT
// STORE | publish averaged result and new_flag
// GAP   | one deselected cycle, advance axis, resample ena
module adc_scan_sched #(
    parameter int SETTLE   = 4,
    parameter int OSR_LOG2 = 3,
    parameter int TIMEOUT  = 255
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    adc_scan_sched_if.master adc,
    input  logic             ena_i,
    input  logic [2:0]       clr_new_i,
    input  logic             clr_err_i,
    output logic [12:0]      x_data_o,
    output logic [12:0]      y_data_o,
    output logic [12:0]      z_data_o,
    output logic [2:0]       new_flag_o,
    output logic             err_o,
    output logic             frame_done_o,
    output logic             busy_o
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SEL   = 3'd1;
    localparam logic [2:0] S_CONV  = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_STORE = 3'd4;
    localparam logic [2:0] S_GAP   = 3'd5;

    localparam logic [1:0] AX_X = 2'd0;
    localparam logic [1:0] AX_Y = 2'd1;
    localparam logic [1:0] AX_Z = 2'd2;

    localparam int AW = 13 + OSR_LOG2;
    localparam int CW = OSR_LOG2 + 1;
    localparam logic [7:0]    SETTLE_LD = 8'(SETTLE - 1);
    localparam logic [7:0]    TMO_LD    = 8'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_LD    = CW'((1 << OSR_LOG2) - 1);

    logic [2:0]    state_q, state_d;
    logic [1:0]    axis_q, axis_d;
    logic [7:0]    settle_q, settle_d;
    logic [7:0]    tmo_q, tmo_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] acc_q, acc_d;
    logic [12:0]   x_q, x_d, y_q, y_d, z_q, z_d;
    logic [2:0]    nf_q, nf_d;
    logic          err_q, err_d;
    logic          store_en;
    logic          tmo_hit;
    logic          active;
    logic [12:0]   avg;
    logic [2:0]    nf_set;

    assign avg = 13'(acc_q >> OSR_LOG2);

    // Timers are down-counters loaded with (length - 1); terminal count is zero.
    always_comb begin
        state_d  = state_q;
        axis_d   = axis_q;
        settle_d = settle_q;
        tmo_d    = tmo_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        store_en = 1'b0;
        tmo_hit  = 1'b0;
        case (state_q)
            S_IDLE: begin
                acc_d = '0;
                cnt_d = CNT_LD;
                if (ena_i) begin
                    state_d  = S_SEL;
                    axis_d   = AX_X;
                    settle_d = SETTLE_LD;
                end
            end
            S_SEL: begin
                if (settle_q == 8'd0) state_d = S_CONV;
                else                  settle_d = settle_q - 8'd1;
            end
            S_CONV: begin
                tmo_d   = TMO_LD;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A sample arriving on the timeout cycle is still accepted.
                if (adc.adc_valid) begin
                    acc_d = acc_q + AW'(adc.adc_data);
                    if (cnt_q == '0) begin
                        state_d = S_STORE;
                    end else begin
                        cnt_d   = cnt_q - 1'b1;
                        state_d = S_CONV;
                    end
                end else if (tmo_q == 8'd0) begin
                    tmo_hit = 1'b1;
                    state_d = S_GAP;
                end else begin
                    tmo_d = tmo_q - 8'd1;
                end
            end
            S_STORE: begin
                store_en = 1'b1;
                state_d  = S_GAP;
            end
            S_GAP: begin
                acc_d    = '0;
                cnt_d    = CNT_LD;
                axis_d   = (axis_q == AX_Z) ? AX_X : axis_q + 2'd1;
                settle_d = SETTLE_LD;
                state_d  = ena_i ? S_SEL : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        z_d    = z_q;
        nf_set = 3'b000;
        if (store_en) begin
            nf_set = 3'b001 << axis_q;
            case (axis_q)
                AX_X:    x_d = avg;
                AX_Y:    y_d = avg;
                default: z_d = avg;
            endcase
        end
        nf_d  = (nf_q & ~clr_new_i) | nf_set;
        err_d = (err_q & ~clr_err_i) | tmo_hit;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            axis_q   <= AX_X;
            settle_q <= 8'd0;
            tmo_q    <= 8'd0;
            cnt_q    <= '0;
            acc_q    <= '0;
            x_q      <= 13'd0;
            y_q      <= 13'd0;
            z_q      <= 13'd0;
            nf_q     <= 3'b000;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            axis_q   <= axis_d;
            settle_q <= settle_d;
            tmo_q    <= tmo_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            x_q      <= x_d;
            y_q      <= y_d;
            z_q      <= z_d;
            nf_q     <= nf_d;
            err_q    <= err_d;
        end
    end

    assign active = (state_q == S_SEL) || (state_q == S_CONV) ||
                    (state_q == S_WAIT) || (state_q == S_STORE);

    assign adc.cs0        = ~(active && (axis_q != AX_Z));
    assign adc.cs1        = ~(active && (axis_q == AX_Z));
    assign adc.ch_sel     = (active && (axis_q == AX_Y)) ? 3'd1 : 3'd0;
    assign adc.conv_start = (state_q == S_CONV);

    assign x_data_o     = x_q;
    assign y_data_o     = y_q;
    assign z_data_o     = z_q;
    assign new_flag_o   = nf_q;
    assign err_o        = err_q;
    assign frame_done_o = (state_q == S_GAP) && (axis_q == AX_Z);
    assign busy_o       = (state_q != S_IDLE);
endmodule

// File: tb/tb_adc_scan_sched.sv
// Randomized bench for adc_scan_sched: conversion plans with expected results and frame timing.
module tb_adc_scan_sched;
    localparam int SETTLE = 4;
    localparam int OSR    = 3;
    localparam int TMO    = 255;
    localparam int NS     = 1 << OSR;
    localparam int S4     = 2;

    typedef struct {
        int axis;
        int data;
        int dly;
        bit drop;
    } conv_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    adc_scan_sched_if adc_if ();
    adc_scan_sched_if adc4_if ();

    logic        ena = 1'b0;
    logic [2:0]  clr_new = 3'b000;
    logic        clr_err = 1'b0;
    logic [12:0] x_data, y_data, z_data;
    logic [2:0]  new_flag;
    logic        err, frame_done, busy;

    logic        ena4 = 1'b0;
    logic [2:0]  clr4 = 3'b000;
    logic        clre4 = 1'b0;
    logic [12:0] x4, y4, z4;
    logic [2:0]  nf4;
    logic        err4, fd4, busy4;

    adc_scan_sched #(.SETTLE(SETTLE), .OSR_LOG2(OSR), .TIMEOUT(TMO)) dut (
        .clk_i(clk), .rst_ni(rst_n), .adc(adc_if.master),
        .ena_i(ena), .clr_new_i(clr_new), .clr_err_i(clr_err),
        .x_data_o(x_data), .y_data_o(y_data), .z_data_o(z_data),
        .new_flag_o(new_flag), .err_o(err), .frame_done_o(frame_done), .busy_o(busy)
    );

    adc_scan_sched #(.SETTLE(S4), .OSR_LOG2(4), .TIMEOUT(20)) dut4 (
        .clk_i(clk), .rst_ni(rst_n), .adc(adc4_if.master),
        .ena_i(ena4), .clr_new_i(clr4), .clr_err_i(clre4),
        .x_data_o(x4), .y_data_o(y4), .z_data_o(z4),
        .new_flag_o(nf4), .err_o(err4), .frame_done_o(fd4), .busy_o(busy4)
    );

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // {cs0, cs1, ch_sel} required while an axis is addressed
    function automatic logic [4:0] exp_sel(input int ax);
        case (ax)
            0:       return 5'b01_000;
            1:       return 5'b01_001;
            default: return 5'b10_000;
        endcase
    endfunction

    conv_t plan[$];
    conv_t rsp_cur;
    int    rsp_cnt = 0;
    bit    spur_en = 1'b0;
    int    exp_data[3] = '{0, 0, 0};
    logic [2:0] exp_nf = 3'b000;
    logic  exp_err = 1'b0;

    // ADC model: answers each conv_start from the plan after the planned delay
    initial begin
        adc_if.adc_valid = 1'b0;
        adc_if.adc_data  = 13'd0;
        forever begin
            @(negedge clk);
            adc_if.adc_valid = 1'b0;
            if (!rst_n) rsp_cnt = 0;
            if (rsp_cnt > 0) begin
                rsp_cnt--;
                if (rsp_cnt == 0 && !rsp_cur.drop) begin
                    adc_if.adc_valid = 1'b1;
                    adc_if.adc_data  = 13'(rsp_cur.data);
                end
            end
            if (rst_n && adc_if.conv_start) begin
                check_val("plan_avail", 32'(plan.size() != 0), 1);
                if (plan.size() != 0) begin
                    rsp_cur = plan.pop_front();
                    check_val("cs_axis", {adc_if.cs0, adc_if.cs1, adc_if.ch_sel}, exp_sel(rsp_cur.axis));
                    rsp_cnt = rsp_cur.dly;
                end
            end else if (spur_en && rsp_cnt == 0 && !adc_if.adc_valid && $urandom_range(0, 3) == 0) begin
                adc_if.adc_valid = 1'b1;
                adc_if.adc_data  = 13'($urandom);
            end
        end
    end

    bit pend4 = 1'b0;
    initial begin
        adc4_if.adc_valid = 1'b0;
        adc4_if.adc_data  = 13'h1fff;
        forever begin
            @(negedge clk);
            adc4_if.adc_valid = pend4;
            pend4 = adc4_if.conv_start;
        end
    end

    // mode: 0 random, 1 constant 100 with d=1, 2 ramp on X, 3 full scale with d=1
    task automatic run_frame(input int mode, input int drop_ax, input int n_ax, input bit clr_st);
        int len[3];
        int res[3];
        int sum, kd, d, dat, target, n, fd_cyc;
        conv_t e;
        plan.delete();
        spur_en = (mode == 0 && drop_ax > 2);
        for (int a = 0; a < 3; a++) begin
            sum = 0;
            len[a] = SETTLE + 1;
            kd = (a == drop_ax) ? $urandom_range(0, NS - 1) : NS;
            for (int i = 0; i <= kd && i < NS; i++) begin
                d = (mode == 1 || mode == 3) ? 1 : $urandom_range(1, 3);
                case (mode)
                    1:       dat = 100;
                    2:       dat = (a == 0) ? i : $urandom_range(0, 8191);
                    3:       dat = 8191;
                    default: dat = $urandom_range(0, 8191);
                endcase
                e.axis = a; e.data = dat; e.dly = d; e.drop = (i == kd);
                if (a < n_ax) plan.push_back(e);
                if (e.drop) len[a] += 1 + TMO;
                else begin
                    len[a] += 1 + d;
                    sum += dat;
                end
            end
            if (kd == NS) len[a] += 1;
            res[a] = sum >> OSR;
        end
        target = 0;
        for (int a = 0; a < n_ax; a++) target += len[a];
        fd_cyc = 0;
        n = 0;
        @(negedge clk);
        ena = 1'b1;
        while (n < target) begin
            @(negedge clk);
            n++;
            clr_new = (clr_st && n == len[0] - 1) ? 3'b001 : 3'b000;
            if (frame_done && fd_cyc == 0) fd_cyc = n;
            if (n == len[0] - 1 && drop_ax != 0) check_val("x_pre_store", x_data, exp_data[0]);
            if (n == len[0] && drop_ax != 0) begin
                check_val("x_upd", x_data, res[0]);
                check_val("x_flag", new_flag[0], 1);
            end
            if (n_ax < 3 && n == len[0] + 1) ena = 1'b0;
            if (n == target) begin
                check_val("busy_last", busy, 1);
                ena = 1'b0;
            end
        end
        @(negedge clk);
        clr_new = 3'b000;
        spur_en = 1'b0;
        for (int a = 0; a < n_ax; a++) begin
            if (a == drop_ax) exp_err = 1'b1;
            else begin
                exp_data[a] = res[a];
                exp_nf[a]   = 1'b1;
            end
        end
        check_val("frame_done_cyc", fd_cyc, (n_ax == 3) ? target : 0);
        check_val("fd_pulse", frame_done, 0);
        check_val("busy_idle", busy, 0);
        check_val("cs_idle", {adc_if.cs0, adc_if.cs1, adc_if.ch_sel}, 5'b11_000);
        check_val("x_data", x_data, exp_data[0]);
        check_val("y_data", y_data, exp_data[1]);
        check_val("z_data", z_data, exp_data[2]);
        check_val("new_flag", new_flag, exp_nf);
        check_val("err", err, exp_err);
        check_val("plan_used", plan.size(), 0);
    endtask

    task automatic clear_flags();
        @(negedge clk);
        clr_new = 3'b111;
        clr_err = 1'b1;
        @(negedge clk);
        clr_new = 3'b000;
        clr_err = 1'b0;
        exp_nf  = 3'b000;
        exp_err = 1'b0;
        check_val("clr_new", new_flag, exp_nf);
        check_val("clr_err", err, exp_err);
    endtask

    task automatic osr4_frame();
        int n, fd;
        n = 0;
        fd = 0;
        @(negedge clk);
        ena4 = 1'b1;
        while (n < 300 && fd == 0) begin
            @(negedge clk);
            n++;
            if (fd4) fd = n;
        end
        ena4 = 1'b0;
        check_val("osr4_frame_cyc", fd, 3 * (S4 + (1 << 4) * 2 + 2));
        @(negedge clk);
        check_val("osr4_x", x4, 8191);
        check_val("osr4_y", y4, 8191);
        check_val("osr4_z", z4, 8191);
        check_val("osr4_flag", nf4, 7);
        check_val("osr4_err", err4, 0);
        check_val("osr4_busy", busy4, 0);
    endtask

    task automatic mid_reset();
        conv_t e;
        bit seen;
        plan.delete();
        for (int i = 0; i < NS; i++) begin
            e.axis = 0; e.data = $urandom_range(0, 8191); e.dly = 3; e.drop = 1'b0;
            plan.push_back(e);
        end
        seen = 1'b0;
        @(negedge clk);
        ena = 1'b1;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = adc_if.conv_start;
        end
        check_val("conv_seen", seen, 1);
        @(negedge clk);
        check_val("busy_pre_rst", busy, 1);
        #2 rst_n = 1'b0;
        ena = 1'b0;
        #1;
        check_val("rst_cs", {adc_if.cs0, adc_if.cs1, adc_if.ch_sel}, 5'b11_000);
        check_val("rst_conv", adc_if.conv_start, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_data", {x_data, y_data, z_data}, 0);
        check_val("rst_flags", {new_flag, err, frame_done}, 0);
        plan.delete();
        exp_data = '{0, 0, 0};
        exp_nf   = 3'b000;
        exp_err  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_val("por_busy", busy, 0);
        check_val("por_cs", {adc_if.cs0, adc_if.cs1, adc_if.ch_sel}, 5'b11_000);
        check_val("por_conv", adc_if.conv_start, 0);
        check_val("por_flags", {new_flag, err, frame_done}, 0);
        check_val("por_data", {x_data, y_data, z_data}, 0);
        rst_n = 1'b1;

        run_frame(1, 3, 3, 1'b0);
        clear_flags();
        run_frame(2, 3, 3, 1'b1);
        check_val("x_trunc", x_data, 3);
        clear_flags();
        for (int r = 0; r < 3; r++) begin
            run_frame(0, 3, 3, 1'b0);
            clear_flags();
        end
        run_frame(0, 1, 3, 1'b0);
        clear_flags();
        run_frame(3, 3, 3, 1'b0);
        run_frame(0, 3, 2, 1'b0);
        osr4_frame();
        mid_reset();
        run_frame(0, 3, 3, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/adc_scan_sched.md
# adc_scan_sched

Scan sequencer for the accelerometer ADC pair. It owns the chip selects and channel select and walks the X, Y and Z axes in a fixed round-robin. For each axis it issues 2^OSR_LOG2 conversion strobes, accumulates the returned samples and publishes the averaged result in a per-axis register with a new-data flag. It sits between the ADC capture logic and the wishbone register file in the wb_adc subsystem.

## Interface
- SETTLE, 4: cycles that cs/ch_sel are held stable before the first conversion strobe of an axis (1..255)
- OSR_LOG2, 3: log2 of the samples averaged per axis (0..4)
- TIMEOUT, 255: maximum cycles spent waiting for adc_valid after a strobe (1..255)
- clk  in  1  system clock; all logic on the rising edge
- rst  in  1  reset, asynchronous and active-low (0 = reset)
- ena  in  1  scan enable; level, sampled only in IDLE and GAP
- adc_data  in  13  unsigned conversion result; qualified by adc_valid
- adc_valid  in  1  one-cycle strobe: adc_data is valid
- clr_new  in  3  one-hot per axis {Z,Y,X}; clears the matching new_flag
- clr_err  in  1  clears err
- cs0  out  1  chip select, X/Y device, active-low
- cs1  out  1  chip select, Z device, active-low
- ch_sel  out  3  ADC channel select
- conv_start  out  1  one-cycle conversion request
- x_data, y_data, z_data  out  13 each  averaged results
- new_flag  out  3  {Z,Y,X} sticky, set on result update
- err  out  1  sticky; set on a timeout
- frame_done  out  1  one-cycle pulse after the Z axis completes
- busy  out  1  high in every state except IDLE

## Operation
- Axis mapping:
  - X: cs0=0, cs1=1, ch_sel=0
  - Y: cs0=0, cs1=1, ch_sel=1
  - Z: cs0=1, cs1=0, ch_sel=0
  - Outside SEL, CONV, WAIT and STORE: cs0=cs1=1 and ch_sel=0.
- States: IDLE, SEL, CONV, WAIT, STORE, GAP.
- IDLE: when ena=1, go to SEL with axis=X; clear the accumulator and the sample count.
- SEL: drive the axis mapping for SETTLE cycles, then go to CONV.
- CONV: conv_start=1 for exactly 1 cycle, clear the timeout counter, go to WAIT.
- WAIT, when adc_valid=1:
  - acc += adc_data, count++.
  - If count reaches 2^OSR_LOG2, go to STORE; otherwise go to CONV.
- WAIT, timeout: when the counter reaches TIMEOUT without adc_valid:
  - Set err, discard acc, leave the axis register and its new_flag unchanged, go to GAP.
  - If adc_valid and the timeout occur in the same cycle, adc_valid wins.
- STORE: result = acc >> OSR_LOG2 (truncating). Write the axis register, set new_flag[axis], go to GAP.
- GAP: chip selects deasserted for 1 cycle.
  - Advance the axis X→Y→Z→X.
  - On leaving Z, pulse frame_done in this cycle.
  - Next state: SEL if ena=1, IDLE otherwise. Clear acc and count.
- Accumulator is 13+OSR_LOG2 bits wide and unsigned; it cannot overflow.
- adc_valid outside WAIT is ignored.
- ena=0 mid-axis has no effect until GAP; the current axis always completes.
- If clr_new[i] and the set of new_flag[i] occur in the same cycle, set wins. The same rule applies to err/clr_err.
- Reset values:
  - State IDLE; cs0=cs1=1; ch_sel=0; conv_start=0.
  - x/y/z_data=0; new_flag=0; err=0; frame_done=0; busy=0.
  - acc and all counters 0.
- Reset asserted mid-scan returns the block to IDLE asynchronously. No partial result is written.

## Timing
- Per sample: CONV (1 cycle) + WAIT (d cycles, where adc_valid arrives d≥1 cycles after conv_start).
- Per axis: SETTLE + 2^OSR_LOG2·(1+d) + 1 (STORE) + 1 (GAP).
- With defaults and d=1: 4+16+1+1 = 22 cycles per axis, 66 cycles per frame.
- The first conv_start occurs on cycle SETTLE+1 after ena is sampled high in IDLE.
- An axis register updates on the clock edge leaving STORE; new_flag is visible in the same cycle.
- A timed-out axis occupies SETTLE + k·(1+d) + 1 + TIMEOUT + 1 cycles, where k is the number of samples taken before the timeout.

## Test plan
- Defaults; the ADC model returns adc_data=100 with d=1; ena=1 for one frame → x_data=y_data=z_data=100, new_flag=3'b111, frame_done pulses at cycle 66, and cs/ch_sel follow the axis mapping.
- Samples 0,1,2,…,7 on X → x_data=3 (28>>3), confirming truncation.
- All samples 8191 with OSR_LOG2=4 → result 8191, no overflow.
- ADC model drops adc_valid on Y → err=1 after 255 WAIT cycles, y_data keeps its previous value, new_flag[1] stays 0, and the scan continues to Z.
- Deassert ena during Y's SEL → Y and then GAP complete, the block enters IDLE with busy=0 and cs0=cs1=1, and no Z access occurs.
- Assert rst low in the middle of WAIT → all outputs are at their reset values immediately. Pulse clr_new=3'b001 in the same cycle as X's STORE → new_flag[0]=1.
